// File: rtl/bcd_down_counter_pkg.sv
// Shared constants and helpers for the cascadable BCD down counter.
package bcd_down_counter_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BCD_NINE = 4'h9;

  function automatic logic is_bcd_zero(input logic [NIBBLE_W-1:0] nibble);
    return nibble == 4'h0;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the ripple-borrow decrement; purely combinational.
module bcd_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic [NIBBLE_W-1:0] q,
  input  logic                borrow_in,
  output logic [NIBBLE_W-1:0] q_next,
  output logic                borrow_out
);

  // Illegal codes 10..15 fold to nine so a corrupted digit recovers on its next borrow.
  always_comb begin
    q_next = q;
    if (borrow_in) begin
      if (is_bcd_zero(q) || (q > BCD_NINE)) begin
        q_next = BCD_NINE;
      end else begin
        q_next = q - NIBBLE_W'(1);
      end
    end
  end

  assign borrow_out = borrow_in && is_bcd_zero(q);

endmodule

// File: rtl/bcd_down_counter.sv
// DIGITS-digit BCD down counter with clear, load, borrow chaining and optional auto-reload.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter bit          RELOAD = 1'b0
) (
  input  logic                         CLK,
  input  logic                         CD,
  input  logic                         LD,
  input  logic                         EN,
  input  logic                         BI,
  input  logic [NIBBLE_W*DIGITS-1:0]   D,
  output logic [NIBBLE_W*DIGITS-1:0]   Q,
  output logic                         BO,
  output logic                         ZERO,
  output logic                         TC
);

  localparam int unsigned W = NIBBLE_W * DIGITS;

  logic [DIGITS:0] borrow;
  logic [W-1:0]    q_dec;
  logic [W-1:0]    wrap_value;
  logic            dec_en;

  assign borrow[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_down_digit u_digit (
      .q          (Q[NIBBLE_W*k +: NIBBLE_W]),
      .borrow_in  (borrow[k]),
      .q_next     (q_dec[NIBBLE_W*k +: NIBBLE_W]),
      .borrow_out (borrow[k+1])
    );
  end

  // A borrow escaping the top digit means every digit is exactly zero.
  assign ZERO       = borrow[DIGITS];
  assign dec_en     = BI && EN;
  assign BO         = dec_en && ZERO;
  assign wrap_value = RELOAD ? D : {DIGITS{BCD_NINE}};

  // Priority: clear, load, decrement (with underflow handling), hold.
  always_ff @(posedge CLK) begin
    if (CD) begin
      Q  <= '0;
      TC <= 1'b0;
    end else if (LD) begin
      Q  <= D;
      TC <= 1'b0;
    end else if (dec_en) begin
      Q  <= ZERO ? wrap_value : q_dec;
      TC <= ZERO;
    end else begin
      TC <= 1'b0;
    end
  end

endmodule
